// File: rtl/pattern_scheduler.sv
// Pattern select sequencer for the monitor tester: manual/auto pattern choice plus moving-square state.
// Optional build macro BLANK_ON_SWITCH_EN adds a one-frame force-black after each pattern change.
//
// state  | meaning
// MANUAL | pattern follows a valid one-hot switch setting each frame
// AUTO   | pattern index steps every FRAMES_PER_PATTERN frames or on a button press
module pattern_scheduler #(
    parameter int NUM_PATTERNS       = 7,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int SQUARE_SIZE        = 10,
    parameter int H_ACTIVE           = 640,
    parameter int V_ACTIVE           = 480,
    parameter int SPEED              = 2,
    parameter int SQUARE_INDEX       = 6
) (
    input  logic       clock25MHz,
    input  logic       reset,
    input  logic       frameStart,
    input  logic [9:0] switches,
    input  logic       autoMode,
    input  logic       nextPattern,
    output logic [9:0] patternSelect,
    output logic [9:0] squareX,
    output logic [9:0] squareY,
    output logic       patternChanged,
    output logic       blank
);

    localparam logic [0:0] MANUAL = 1'b0;
    localparam logic [0:0] AUTO   = 1'b1;

    localparam int                IDX_W      = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_PATTERNS - 1);
    localparam logic [9:0]        LAST_COUNT = 10'(FRAMES_PER_PATTERN - 1);
    localparam logic [9:0]        SEL_MASK   = 10'((1 << NUM_PATTERNS) - 1);
    localparam logic signed [10:0] STEP      = 11'(SPEED);
    localparam logic signed [10:0] POS_LO    = 11'(SQUARE_SIZE);
    localparam logic signed [10:0] X_HI      = 11'(H_ACTIVE - 1 - SQUARE_SIZE);
    localparam logic signed [10:0] Y_HI      = 11'(V_ACTIVE - 1 - SQUARE_SIZE);

    logic [0:0]       state, state_n;
    logic [IDX_W-1:0] index, index_n;
    logic [9:0]       frame_count, count_n;
    logic             pending;
    logic             next_q;
    logic             vel_x_neg, vel_y_neg;
    logic             rise;
    logic             advance;
    logic             manual_ok;
    logic [9:0]       candidate;
    logic [10:0]      mv_x, mv_y;

    // Returns {reverse, new_position}; 11-bit signed math keeps the edge test free of wrap-around.
    function automatic logic [10:0] move_axis(input logic [9:0] pos, input logic neg,
                                              input logic signed [10:0] hi);
        logic signed [10:0] nxt;
        nxt = $signed({1'b0, pos}) + (neg ? -STEP : STEP);
        if (nxt > hi)
            move_axis = {1'b1, hi[9:0]};
        else if (nxt < POS_LO)
            move_axis = {1'b1, POS_LO[9:0]};
        else
            move_axis = {1'b0, nxt[9:0]};
    endfunction

    assign rise      = nextPattern & ~next_q;
    assign advance   = pending | rise | (frame_count == LAST_COUNT);
    assign manual_ok = ($countones(switches) == 1) && ((switches & ~SEL_MASK) == 10'd0);
    assign mv_x      = move_axis(squareX, vel_x_neg, X_HI);
    assign mv_y      = move_axis(squareY, vel_y_neg, Y_HI);

    always_comb begin
        state_n   = state;
        index_n   = index;
        count_n   = frame_count;
        candidate = 10'd0;
        if (autoMode) begin
            state_n = AUTO;
            if (state == MANUAL) begin
                index_n = '0;
                count_n = 10'd0;
            end else if (advance) begin
                index_n = (index == LAST_IDX) ? '0 : index + 1'b1;
                count_n = 10'd0;
            end else begin
                count_n = frame_count + 10'd1;
            end
            candidate = 10'd1 << index_n;
        end else begin
            state_n   = MANUAL;
            count_n   = 10'd0;
            candidate = manual_ok ? switches : 10'd0;
        end
    end

    always_ff @(posedge clock25MHz or posedge reset) begin
        if (reset) begin
            state          <= MANUAL;
            index          <= '0;
            frame_count    <= 10'd0;
            pending        <= 1'b0;
            next_q         <= 1'b0;
            patternSelect  <= 10'd0;
            patternChanged <= 1'b0;
            squareX        <= 10'd100;
            squareY        <= 10'd100;
            vel_x_neg      <= 1'b0;
            vel_y_neg      <= 1'b0;
        end else begin
            next_q         <= nextPattern;
            patternChanged <= 1'b0;
            if (frameStart) begin
                state          <= state_n;
                index          <= index_n;
                frame_count    <= count_n;
                pending        <= 1'b0;
                patternSelect  <= candidate;
                patternChanged <= (candidate != patternSelect);
                if (patternSelect[SQUARE_INDEX]) begin
                    squareX   <= mv_x[9:0];
                    squareY   <= mv_y[9:0];
                    vel_x_neg <= vel_x_neg ^ mv_x[10];
                    vel_y_neg <= vel_y_neg ^ mv_y[10];
                end
            end else if (rise && state == AUTO) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef BLANK_ON_SWITCH_EN
    // Held from a changing frame boundary until the following boundary.
    always_ff @(posedge clock25MHz or posedge reset) begin
        if (reset)
            blank <= 1'b0;
        else if (frameStart)
            blank <= (candidate != patternSelect);
    end
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed self-checking bench for pattern_scheduler (auto hold shortened to 3 frames).
module tb_pattern_scheduler;

`ifdef BLANK_ON_SWITCH_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       frameStart;
    logic [9:0] switches;
    logic       autoMode;
    logic       nextPattern;
    logic [9:0] patternSelect;
    logic [9:0] squareX;
    logic [9:0] squareY;
    logic       patternChanged;
    logic       blank;

    int vectors    = 0;
    int miscompares = 0;

    pattern_scheduler #(.FRAMES_PER_PATTERN(3)) dut (
        .clock25MHz    (clk),
        .reset         (reset),
        .frameStart    (frameStart),
        .switches      (switches),
        .autoMode      (autoMode),
        .nextPattern   (nextPattern),
        .patternSelect (patternSelect),
        .squareX       (squareX),
        .squareY       (squareY),
        .patternChanged(patternChanged),
        .blank         (blank)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the falling edge just after the frameStart edge.
    task automatic pulse_frame();
        repeat (3) @(negedge clk);
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
    endtask

    initial begin
        logic [9:0] e;
        reset = 1'b1; frameStart = 1'b0; switches = 10'd0; autoMode = 1'b0; nextPattern = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sel", patternSelect, 10'h000);
        check("rst_x", squareX, 10'd100);
        check("rst_y", squareY, 10'd100);
        check("rst_chg", patternChanged, 1'b0);
        check("rst_blank", blank, 1'b0);
        reset = 1'b0;

        // Button presses in manual mode must not leave a pending advance behind.
        @(negedge clk) nextPattern = 1'b1;
        @(negedge clk) nextPattern = 1'b0;

        switches = 10'h004;
        pulse_frame();
        check("man_004_sel", patternSelect, 10'h004);
        check("man_004_chg", patternChanged, 1'b1);
        check("man_004_blank", blank, BLANK_EN);
        @(negedge clk);
        check("man_004_chg_end", patternChanged, 1'b0);

        switches = 10'h006;
        pulse_frame();
        check("man_006_sel", patternSelect, 10'h000);
        check("man_006_chg", patternChanged, 1'b1);
        check("man_006_blank", blank, BLANK_EN);

        switches = 10'h200;
        pulse_frame();
        check("man_200_sel", patternSelect, 10'h000);
        check("man_200_chg", patternChanged, 1'b0);
        check("man_200_blank", blank, 1'b0);

        // autoMode pulse between frame boundaries is never seen.
        @(negedge clk) autoMode = 1'b1;
        repeat (2) @(negedge clk);
        autoMode = 1'b0;
        pulse_frame();
        check("midframe_auto_sel", patternSelect, 10'h000);

        autoMode = 1'b1;
        for (int p = 1; p <= 22; p++) begin
            pulse_frame();
            e = 10'd1 << (((p - 1) / 3) % 7);
            check($sformatf("auto_sel_%0d", p), patternSelect, e);
            check($sformatf("auto_chg_%0d", p), patternChanged, (p % 3) == 1);
            check($sformatf("auto_blank_%0d", p), blank, BLANK_EN && ((p % 3) == 1));
        end

        // Two presses inside one frame: a single step, then a fresh 3-frame hold.
        @(negedge clk) nextPattern = 1'b1;
        repeat (2) @(negedge clk);
        nextPattern = 1'b0;
        repeat (2) @(negedge clk);
        nextPattern = 1'b1;
        @(negedge clk) nextPattern = 1'b0;
        pulse_frame();
        check("np_sel_a", patternSelect, 10'h002);
        check("np_chg_a", patternChanged, 1'b1);
        pulse_frame();
        check("np_sel_b", patternSelect, 10'h002);
        pulse_frame();
        check("np_sel_c", patternSelect, 10'h002);
        pulse_frame();
        check("np_sel_d", patternSelect, 10'h004);

        // Press landing in the same cycle as frameStart advances at that boundary.
        repeat (3) @(negedge clk);
        frameStart = 1'b1; nextPattern = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        check("np_same_cycle", patternSelect, 10'h008);
        @(negedge clk) nextPattern = 1'b0;
        pulse_frame();
        check("np_no_leftover", patternSelect, 10'h008);

        autoMode = 1'b0; switches = 10'h010;
        pulse_frame();
        check("auto_to_man", patternSelect, 10'h010);

        // Square moved during the 0x040 auto frames; async reset must restore it between edges.
        check("pre_rst_x", squareX, 10'd106);
        #5 reset = 1'b1;
        #1;
        check("async_rst_sel", patternSelect, 10'h000);
        check("async_rst_x", squareX, 10'd100);
        check("async_rst_y", squareY, 10'd100);
        check("async_rst_chg", patternChanged, 1'b0);
        check("async_rst_blank", blank, 1'b0);
        @(negedge clk) reset = 1'b0;

        switches = 10'h040;
        pulse_frame();
        check("sq_sel", patternSelect, 10'h040);
        check("sq_x0", squareX, 10'd100);
        for (int k = 1; k <= 266; k++) begin
            pulse_frame();
            if (k == 184) begin
                check("sq_y184", squareY, 10'd468);
            end else if (k == 185) begin
                check("sq_y185_clamp", squareY, 10'd469);
                check("sq_x185", squareX, 10'd470);
            end else if (k == 186) begin
                check("sq_y186_back", squareY, 10'd467);
            end else if (k == 263) begin
                check("sq_x263", squareX, 10'd626);
                check("sq_y263", squareY, 10'd313);
            end else if (k == 264) begin
                check("sq_x264", squareX, 10'd628);
            end else if (k == 265) begin
                check("sq_x265_clamp", squareX, 10'd629);
            end else if (k == 266) begin
                check("sq_x266_back", squareX, 10'd627);
                check("sq_y266", squareY, 10'd307);
            end
        end

        switches = 10'h001;
        pulse_frame();
        check("sq_last_move_x", squareX, 10'd625);
        check("sq_last_move_y", squareY, 10'd305);
        check("sq_sel_001", patternSelect, 10'h001);
        pulse_frame();
        pulse_frame();
        check("sq_hold_x", squareX, 10'd625);
        check("sq_hold_y", squareY, 10'd305);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
